// File: rtl/fifo2axis_pkg.sv
// Constants and helpers shared by the FIFO-to-AXIS unpacker and its AXIS-to-FIFO packer.
// Defaults mirror the frame-buffer path configuration.
package fifo2axis_pkg;

    localparam int DEF_AXIS_DATA_WIDTH = 32;
    localparam int DEF_AXI4_DATA_WIDTH = 128;
    localparam int DEF_IMG_WIDTH       = 1920;
    localparam int DEF_IMG_HEIGHT      = 1080;

    localparam int RATIO = DEF_AXI4_DATA_WIDTH / DEF_AXIS_DATA_WIDTH;
    localparam int SEL_W = $clog2(RATIO);
    localparam int X_W   = $clog2(DEF_IMG_WIDTH);
    localparam int Y_W   = $clog2(DEF_IMG_HEIGHT);

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit width_ok(input int wide, input int narrow);
        int r;
        if (narrow <= 0 || (narrow % 8) != 0 || (wide % narrow) != 0) return 1'b0;
        r = wide / narrow;
        return (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo2axis_video_timing_cnt.sv
// Pixel/line counters for an AXI4-Stream video interface: TLAST, start-of-frame USER
// and a frame_done pulse, advanced once per accepted beat.
module video_timing_cnt
    import fifo2axis_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic beat,
    output logic tlast,
    output logic tuser,
    output logic frame_done
);

    localparam int XW = cnt_w(IMG_WIDTH);
    localparam int YW = cnt_w(IMG_HEIGHT);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          frame_done_q, frame_done_d;
    logic          x_last, y_last;

    assign x_last = (x_q == XW'(IMG_WIDTH - 1));
    assign y_last = (y_q == YW'(IMG_HEIGHT - 1));

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = beat & x_last & y_last;
        if (beat) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tlast      = vld & x_last;
    assign tuser      = vld & (x_q == '0) & (y_q == '0);
    assign frame_done = frame_done_q;

endmodule

// File: rtl/fifo2axis.sv
// Unpacks wide FWFT FIFO words into narrow AXI4-Stream video beats, MSB slice first,
// with line/frame sideband from the shared video timing counters.
module fifo2axis
    import fifo2axis_pkg::*;
#(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter int AXI4_DATA_WIDTH = DEF_AXI4_DATA_WIDTH,
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT
) (
    input  logic                         M_AXIS_ACLK,
    input  logic                         M_AXIS_ARESET,
    input  logic                         frd_vld,
    input  logic [AXI4_DATA_WIDTH-1:0]   frd_dat,
    input  logic                         frd_empty,
    input  logic [FAW:0]                 frd_cnt,
    output logic                         frd_rdy,
    output logic                         M_AXIS_TVALID,
    output logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                         M_AXIS_TLAST,
    output logic                         M_AXIS_USER,
    input  logic                         M_AXIS_TREADY,
    output logic                         frame_done
);

    localparam int R  = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int SW = cnt_w(R);

    if (!width_ok(AXI4_DATA_WIDTH, AXIS_DATA_WIDTH)) begin : g_bad_params
        $error("fifo2axis: AXI4_DATA_WIDTH/AXIS_DATA_WIDTH must be a power of two >= 2 and AXIS width a byte multiple");
    end

    logic [AXI4_DATA_WIDTH-1:0] word_buf_q, word_buf_d;
    logic                       word_vld_q, word_vld_d;
    logic [SW-1:0]              sel_q, sel_d;
    logic [R-1:0][AXIS_DATA_WIDTH-1:0] slices;
    logic beat, last_slice, pop;

    // Status inputs are reserved for a future start threshold.
    logic unused_status;
    assign unused_status = frd_empty ^ (^frd_cnt);

    assign slices     = word_buf_q;
    assign beat       = word_vld_q & M_AXIS_TREADY;
    assign last_slice = &sel_q;
    // Refilling on the last-slice beat keeps back-to-back words bubble-free; no pops in reset.
    assign frd_rdy    = !M_AXIS_ARESET & (!word_vld_q | (beat & last_slice));
    assign pop        = frd_rdy & frd_vld;

    always_comb begin
        word_buf_d = word_buf_q;
        word_vld_d = word_vld_q;
        sel_d      = sel_q;
        if (pop) begin
            word_buf_d = frd_dat;
            word_vld_d = 1'b1;
            sel_d      = '0;
        end else if (beat) begin
            if (last_slice) begin
                word_vld_d = 1'b0;
                sel_d      = '0;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            word_buf_q <= '0;
            word_vld_q <= 1'b0;
            sel_q      <= '0;
        end else begin
            word_buf_q <= word_buf_d;
            word_vld_q <= word_vld_d;
            sel_q      <= sel_d;
        end
    end

    video_timing_cnt #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_timing (
        .clk       (M_AXIS_ACLK),
        .rst       (M_AXIS_ARESET),
        .vld       (word_vld_q),
        .beat      (beat),
        .tlast     (M_AXIS_TLAST),
        .tuser     (M_AXIS_USER),
        .frame_done(frame_done)
    );

    // Slice 0 is the most significant lane, so index from the top.
    assign M_AXIS_TVALID = word_vld_q;
    assign M_AXIS_TDATA  = slices[~sel_q];
    assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_fifo2axis.sv
// Directed bench for fifo2axis with a 6x2 frame and 128->32 unpacking.
module tb_fifo2axis;

    localparam int FAW = 4;
    localparam int DW  = 32;
    localparam int WW  = 128;
    localparam int IW  = 6;
    localparam int IH  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frd_vld = 1'b0;
    logic [WW-1:0]   frd_dat = '0;
    logic            frd_empty = 1'b1;
    logic [FAW:0]    frd_cnt = '0;
    logic            frd_rdy;
    logic            tvalid;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tlast;
    logic            tuser;
    logic            tready = 1'b0;
    logic            frame_done;

    always #5 clk = ~clk;

    fifo2axis #(
        .FAW(FAW), .AXIS_DATA_WIDTH(DW), .AXI4_DATA_WIDTH(WW),
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) dut (
        .M_AXIS_ACLK  (clk),
        .M_AXIS_ARESET(rst),
        .frd_vld      (frd_vld),
        .frd_dat      (frd_dat),
        .frd_empty    (frd_empty),
        .frd_cnt      (frd_cnt),
        .frd_rdy      (frd_rdy),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TSTRB (tstrb),
        .M_AXIS_TLAST (tlast),
        .M_AXIS_USER  (tuser),
        .M_AXIS_TREADY(tready),
        .frame_done   (frame_done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          rdy;
        logic          pop;
        int            cyc;
    } beat_t;

    beat_t         beats[$];
    int            fd_cycs[$];
    logic [WW-1:0] fifo[$];
    int            cyc = 0;
    logic          pop_now = 1'b0;
    int            checks = 0;
    int            failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic refresh();
        frd_vld   = (fifo.size() != 0);
        frd_dat   = (fifo.size() != 0) ? fifo[0] : '0;
        frd_empty = (fifo.size() == 0);
        frd_cnt   = (FAW+1)'(fifo.size());
    endtask

    // Monitor samples mid-cycle; inputs only move at posedge+1.
    always @(negedge clk) begin
        pop_now = frd_rdy & frd_vld;
        if (!rst && tvalid && tready)
            beats.push_back('{tdata, tlast, tuser, frd_rdy, frd_rdy & frd_vld, cyc});
        if (frame_done) fd_cycs.push_back(cyc);
    end

    always @(posedge clk) begin
        #1;
        if (pop_now && fifo.size() > 0) fifo.delete(0);
        refresh();
    end

    task automatic push(input logic [WW-1:0] w);
        fifo.push_back(w);
        refresh();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        fifo.delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        beats.delete();
        fd_cycs.delete();
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (beats.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        push({32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004});
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tvalid, tlast, tuser, frame_done, frd_rdy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {tvalid, tlast, tuser, frame_done, frd_rdy});
        end
        checks++;
        if (tstrb !== 4'hf) begin
            failures++;
            $display("FAIL reset_tstrb got=%h exp=f", tstrb);
        end
        checks++;
        if (fifo.size() != 1) begin
            failures++;
            $display("FAIL reset_no_pop got=%0d exp=1", fifo.size());
        end
    endtask

    task automatic test_single_word();
        bit ok;
        int p;
        do_reset();
        tready = 1'b1;
        push({32'h1, 32'h2, 32'h3, 32'h4});
        p = cyc;
        wait_beats(4, ok);
        checks++;
        if (!ok || beats.size() != 4) begin
            failures++;
            $display("FAIL single_count got=%0d exp=4", beats.size());
            return;
        end
        checks++;
        if (beats[0].cyc !== p + 1) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", beats[0].cyc, p + 1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (beats[i].data !== DW'(i + 1) || beats[i].cyc !== beats[0].cyc + i) begin
                failures++;
                $display("FAIL single_beat%0d got=%h@%0d exp=%h@%0d", i, beats[i].data,
                         beats[i].cyc, i + 1, beats[0].cyc + i);
            end
            checks++;
            if (beats[i].rdy !== (i == 3)) begin
                failures++;
                $display("FAIL single_rdy%0d got=%b exp=%b", i, beats[i].rdy, i == 3);
            end
        end
        checks++;
        if (beats[0].user !== 1'b1 || beats[1].user !== 1'b0) begin
            failures++;
            $display("FAIL single_user got=%b%b exp=10", beats[0].user, beats[1].user);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] exp_d [8];
        exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        do_reset();
        tready = 1'b1;
        push({32'hA1, 32'hA2, 32'hA3, 32'hA4});
        push({32'hB1, 32'hB2, 32'hB3, 32'hB4});
        wait_beats(8, ok);
        checks++;
        if (!ok || beats.size() != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=8", beats.size());
            return;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (beats[i].data !== exp_d[i] || beats[i].cyc !== beats[0].cyc + i) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%h@%0d exp=%h@%0d", i, beats[i].data,
                         beats[i].cyc, exp_d[i], beats[0].cyc + i);
            end
        end
        checks++;
        if (beats[3].pop !== 1'b1 || beats[7].rdy !== 1'b1 || beats[7].pop !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pops got=%b%b%b exp=110", beats[3].pop, beats[7].rdy, beats[7].pop);
        end
        checks++;
        if (beats[5].last !== 1'b1 || beats[4].last !== 1'b0 || beats[6].last !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tlast got=%b%b%b exp=010", beats[4].last, beats[5].last, beats[6].last);
        end
    endtask

    task automatic test_backpressure();
        int pat [4];
        logic prev_stall;
        logic [DW-1:0] prev_d;
        logic prev_l, prev_u;
        pat = '{1, 0, 0, 1};
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        prev_u = 1'b0;
        do_reset();
        tready = 1'b0;
        push({32'h10, 32'h11, 32'h12, 32'h13});
        push({32'h14, 32'h15, 32'h16, 32'h17});
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            tready = pat[i % 4][0];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l || tuser !== prev_u) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got=%b/%h/%b%b exp=1/%h/%b%b", cyc, tvalid,
                             tdata, tlast, tuser, prev_d, prev_l, prev_u);
                end
            end
            prev_stall = tvalid & !tready;
            prev_d = tdata;
            prev_l = tlast;
            prev_u = tuser;
        end
        tready = 1'b1;
        checks++;
        if (beats.size() != 8) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=8", beats.size());
            return;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (beats[i].data !== DW'(32'h10 + i)) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h exp=%h", i, beats[i].data, 32'h10 + i);
            end
        end
        checks++;
        if (beats[0].user !== 1'b1 || beats[5].last !== 1'b1 || beats[4].last !== 1'b0) begin
            failures++;
            $display("FAIL bp_sideband got=%b%b%b exp=110", beats[0].user, beats[5].last, beats[4].last);
        end
    endtask

    task automatic test_frame();
        bit ok;
        do_reset();
        tready = 1'b1;
        for (int w = 0; w < 4; w++)
            push({DW'(32'h20 + 4*w), DW'(32'h21 + 4*w), DW'(32'h22 + 4*w), DW'(32'h23 + 4*w)});
        wait_beats(16, ok);
        checks++;
        if (!ok || beats.size() != 16) begin
            failures++;
            $display("FAIL frame_count got=%0d exp=16", beats.size());
            return;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beats[i].last !== (i == 5 || i == 11) || beats[i].user !== (i == 0 || i == 12)
                || beats[i].data !== DW'(32'h20 + i)) begin
                failures++;
                $display("FAIL frame_beat%0d got=%h l%b u%b exp=%h l%b u%b", i, beats[i].data,
                         beats[i].last, beats[i].user, 32'h20 + i, i == 5 || i == 11, i == 0 || i == 12);
            end
        end
        checks++;
        if (fd_cycs.size() != 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=1", fd_cycs.size());
        end else begin
            checks++;
            if (fd_cycs[0] != beats[11].cyc + 1) begin
                failures++;
                $display("FAIL frame_done_cyc got=%0d exp=%0d", fd_cycs[0], beats[11].cyc + 1);
            end
        end
    endtask

    task automatic test_empty_gap();
        bit ok;
        int p;
        do_reset();
        tready = 1'b1;
        push({32'h30, 32'h31, 32'h32, 32'h33});
        p = cyc;
        repeat (10) @(posedge clk);
        #1;
        push({32'h34, 32'h35, 32'h36, 32'h37});
        wait_beats(8, ok);
        checks++;
        if (!ok || beats.size() != 8) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=8", beats.size());
            return;
        end
        checks++;
        if (beats[3].cyc != p + 4 || beats[4].cyc != p + 11) begin
            failures++;
            $display("FAIL gap_timing got=%0d,%0d exp=%0d,%0d", beats[3].cyc, beats[4].cyc, p + 4, p + 11);
        end
        checks++;
        if (beats[4].data !== 32'h34 || beats[4].last !== 1'b0 || beats[4].user !== 1'b0
            || beats[5].last !== 1'b1 || beats[6].last !== 1'b0) begin
            failures++;
            $display("FAIL gap_resume got=%h l%b u%b l%b l%b exp=34 l0 u0 l1 l0", beats[4].data,
                     beats[4].last, beats[4].user, beats[5].last, beats[6].last);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        tready = 1'b1;
        push({32'h40, 32'h41, 32'h42, 32'h43});
        push({32'h50, 32'h51, 32'h52, 32'h53});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tdata !== 32'h42 || frd_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre got=%h rdy%b exp=42 rdy0", tdata, frd_rdy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        beats.delete();
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b%b%b exp=000", tvalid, tlast, tuser);
        end
        wait_beats(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_timeout got=%0d exp=1", beats.size());
            return;
        end
        checks++;
        if (beats[0].data !== 32'h50 || beats[0].user !== 1'b1 || beats[0].last !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first got=%h u%b l%b exp=50 u1 l0", beats[0].data, beats[0].user, beats[0].last);
        end
    endtask

    initial begin
        refresh();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_frame();
        test_empty_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
